apb_rcc_ctrl: RTL and testbench



---
 rtl/apb_rcc_ctrl.sv | 116 +++++++++++
 tb/tb_apb_rcc_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_rcc_ctrl.sv
// APB reset and clock-control block: per-channel divided clock-enable strobes
// and software-triggered, stretched active-low resets with registered outputs.
module apb_rcc_ctrl #(
    parameter int                NUM_CH     = 8,
    parameter int                DIV_W      = 8,
    parameter int                RST_CYCLES = 4,
    parameter logic [NUM_CH-1:0] EN_RESET   = '1,
    parameter int                ADDR_W     = 5
) (
    input  logic              io_ahb_PCLK,
    input  logic              io_ahb_PRESETn,
    input  logic [ADDR_W-1:0] io_ahb_PADDR,
    input  logic              io_ahb_PSEL,
    input  logic              io_ahb_PENABLE,
    input  logic              io_ahb_PWRITE,
    input  logic [31:0]       io_ahb_PWDATA,
    output logic              io_ahb_PREADY,
    output logic [31:0]       io_ahb_PRDATA,
    output logic              io_ahb_PSLVERROR,
    output logic [NUM_CH-1:0] ch_clk_en,
    output logic [NUM_CH-1:0] ch_rst_n
);

    logic [NUM_CH-1:0] enr_q;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] tc;
    logic [DIV_W-1:0]  div_q     [NUM_CH];
    logic [DIV_W-1:0]  cnt_q     [NUM_CH];
    logic [DIV_W-1:0]  div_act_q [NUM_CH];
    logic [7:0]        rc_q      [NUM_CH];
    logic [31:0]       idx;
    logic              access;
    logic              err;
    logic              wr;
    logic              unused_pwdata;

    assign unused_pwdata = ^io_ahb_PWDATA;
    assign idx           = 32'(io_ahb_PADDR);
    assign access        = io_ahb_PRESETn & io_ahb_PSEL & io_ahb_PENABLE;
    assign err           = access & ((idx > 32'(2 + NUM_CH)) |
                                     (io_ahb_PWRITE & (idx == 32'd2)));
    assign wr            = access & io_ahb_PWRITE & ~err;

    assign io_ahb_PREADY    = 1'b1;
    assign io_ahb_PSLVERROR = err;

    always_comb begin
        busy = '0;
        tc   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            busy[i] = (rc_q[i] != 8'd0);
            tc[i]   = (cnt_q[i] == div_act_q[i]);
        end
    end

    always_comb begin
        io_ahb_PRDATA = '0;
        if (access && !io_ahb_PWRITE && !err) begin
            case (idx)
                32'd0:   io_ahb_PRDATA[NUM_CH-1:0] = enr_q;
                32'd1:   io_ahb_PRDATA[NUM_CH-1:0] = busy;
                32'd2:   io_ahb_PRDATA[NUM_CH-1:0] = enr_q & ~busy;
                default: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (idx == 32'(3 + i))
                            io_ahb_PRDATA[DIV_W-1:0] = div_q[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
        if (!io_ahb_PRESETn) begin
            enr_q <= EN_RESET;
            for (int unsigned i = 0; i < NUM_CH; i++)
                div_q[i] <= '0;
        end else if (wr) begin
            if (idx == 32'd0)
                enr_q <= io_ahb_PWDATA[NUM_CH-1:0];
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (idx == 32'(3 + i))
                    div_q[i] <= io_ahb_PWDATA[DIV_W-1:0];
            end
        end
    end

    // TC reloads div_act from the pre-write DIV value, so a DIV write lands one period later.
    always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
        if (!io_ahb_PRESETn) begin
            ch_clk_en <= '0;
            ch_rst_n  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                div_act_q[i] <= '0;
                rc_q[i]      <= 8'(RST_CYCLES);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (tc[i]) begin
                    cnt_q[i]     <= '0;
                    div_act_q[i] <= div_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
                if (wr && (idx == 32'd1) && io_ahb_PWDATA[i])
                    rc_q[i] <= 8'(RST_CYCLES);
                else if (busy[i])
                    rc_q[i] <= rc_q[i] - 8'd1;
                ch_clk_en[i] <= busy[i] | (tc[i] & enr_q[i]);
                ch_rst_n[i]  <= ~busy[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_rcc_ctrl.sv
// Self-checking bench for apb_rcc_ctrl: edge-counting behavioural model plus
// directed register/strobe/reset scenarios with literal expectations.
module tb_apb_rcc_ctrl;

    localparam int NUM_CH = 8;
    localparam int RST    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        perr;
    logic [7:0]  clk_en;
    logic [7:0]  crst_n;

    apb_rcc_ctrl #(
        .NUM_CH(NUM_CH), .DIV_W(8), .RST_CYCLES(RST), .EN_RESET(8'hFF), .ADDR_W(5)
    ) dut (
        .io_ahb_PCLK(clk), .io_ahb_PRESETn(rst_n), .io_ahb_PADDR(paddr),
        .io_ahb_PSEL(psel), .io_ahb_PENABLE(penable), .io_ahb_PWRITE(pwrite),
        .io_ahb_PWDATA(pwdata), .io_ahb_PREADY(pready), .io_ahb_PRDATA(prdata),
        .io_ahb_PSLVERROR(perr), .ch_clk_en(clk_en), .ch_rst_n(crst_n)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Model: edges counted from reset release; busy/strobe derived from absolute edge numbers.
    int         ecount;
    int         rst_end [NUM_CH];
    int         next_tc [NUM_CH];
    int         m_div   [NUM_CH];
    logic [7:0] m_enr;
    logic [7:0] exp_en;
    logic [7:0] exp_rstn;
    int         hicnt   [NUM_CH];
    int         lowcnt4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_err(input logic [4:0] a, input logic w);
        return (int'(a) > 2 + NUM_CH) || (w && a == 5'd2);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        logic [31:0] r = '0;
        logic [7:0]  b = '0;
        for (int i = 0; i < NUM_CH; i++) b[i] = (ecount + 1 < rst_end[i]);
        if (a == 5'd0) r[7:0] = m_enr;
        else if (a == 5'd1) r[7:0] = b;
        else if (a == 5'd2) r[7:0] = m_enr & ~b;
        else if (int'(a) <= 2 + NUM_CH) r[7:0] = 8'(m_div[int'(a) - 3]);
        return r;
    endfunction

    task automatic model_reset();
        ecount   = 0;
        m_enr    = 8'hFF;
        exp_en   = '0;
        exp_rstn = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rst_end[i] = RST + 1;
            next_tc[i] = 1;
            m_div[i]   = 0;
        end
    endtask

    task automatic model_step();
        int  n;
        logic b, t;
        ecount++;
        n = ecount;
        for (int i = 0; i < NUM_CH; i++) begin
            b = (n < rst_end[i]);
            t = (n == next_tc[i]);
            exp_en[i]   = b | (t & m_enr[i]);
            exp_rstn[i] = !b;
            if (t) next_tc[i] = n + m_div[i] + 1;
        end
        if (psel && penable && pwrite && !m_err(paddr, 1'b1)) begin
            if (paddr == 5'd0) m_enr = pwdata[7:0];
            else if (paddr == 5'd1) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (pwdata[i]) rst_end[i] = n + RST + 1;
            end else m_div[int'(paddr) - 3] = int'(pwdata[7:0]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_n) model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_clk_en", 32'(clk_en), 32'h0);
            chk("rst_ch_rst_n", 32'(crst_n), 32'h0);
            chk("rst_prdata", prdata, 32'h0);
            chk("rst_pslverr", 32'(perr), 32'h0);
        end else begin
            chk("clk_en", 32'(clk_en), 32'(exp_en));
            chk("ch_rst_n", 32'(crst_n), 32'(exp_rstn));
            chk("pready", 32'(pready), 32'h1);
            chk("pslverr", 32'(perr), 32'(psel & penable & m_err(paddr, pwrite)));
            chk("prdata", prdata,
                (psel && penable && !pwrite && !m_err(paddr, 1'b0)) ? m_rdata(paddr) : 32'h0);
            for (int i = 0; i < NUM_CH; i++) if (clk_en[i]) hicnt[i]++;
            if (!crst_n[4]) lowcnt4++;
        end
    end

    // Bus tasks start at posedge+1 and return at posedge+1, allowing back-to-back accesses.
    task automatic apb_wr(input logic [4:0] a, input logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); e = perr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [4:0] a, output logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); d = prdata; e = perr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        e;

    initial begin
        model_reset();
        for (int i = 0; i < NUM_CH; i++) hicnt[i] = 0;
        lowcnt4 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        apb_rd(5'd2, rd, e);  chk("status_busy", rd, 32'h0);
        apb_rd(5'd0, rd, e);  chk("enr_reset", rd, 32'hFF);
        cycles(6);
        apb_rd(5'd2, rd, e);  chk("status_idle", rd, 32'hFF);

        apb_wr(5'd5, 32'h3, e);  chk("div2_wr_err", 32'(e), 32'h0);
        apb_rd(5'd5, rd, e);     chk("div2_readback", rd, 32'h3);
        cycles(2);
        hicnt[2] = 0;
        cycles(16);
        chk("div3_strobes_in_16", 32'(hicnt[2]), 32'd4);
        apb_wr(5'd5, 32'h0, e);
        cycles(6);
        hicnt[2] = 0;
        cycles(8);
        chk("div0_strobes_in_8", 32'(hicnt[2]), 32'd8);

        apb_wr(5'd3, 32'h2, e);
        cycles(5);
        apb_wr(5'd0, 32'hFE, e);
        cycles(4);
        hicnt[0] = 0;
        cycles(6);
        chk("gated_ch0_strobes", 32'(hicnt[0]), 32'd0);
        apb_wr(5'd0, 32'hFF, e);
        cycles(6);

        lowcnt4 = 0;
        apb_wr(5'd1, 32'h10, e);
        apb_wr(5'd1, 32'h10, e);
        apb_rd(5'd1, rd, e);  chk("rstr_busy_read", rd, 32'h10);
        cycles(10);
        chk("retrigger_low_len", 32'(lowcnt4), 32'd6);
        lowcnt4 = 0;
        apb_wr(5'd1, 32'h10, e);
        cycles(10);
        chk("single_low_len", 32'(lowcnt4), 32'd4);

        apb_rd(5'd11, rd, e);  chk("oob_rd_err", 32'(e), 32'h1);  chk("oob_rd_data", rd, 32'h0);
        apb_wr(5'd2, 32'h0, e);  chk("status_wr_err", 32'(e), 32'h1);
        apb_wr(5'd20, 32'hFFFF, e);  chk("oob_wr_err", 32'(e), 32'h1);
        apb_rd(5'd0, rd, e);  chk("enr_unchanged", rd, 32'hFF);
        apb_rd(5'd3, rd, e);  chk("valid_rd_err", 32'(e), 32'h0);  chk("div0_read", rd, 32'h2);

        apb_wr(5'd4, 32'h5, e);
        apb_wr(5'd1, 32'h01, e);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_clk_en", 32'(clk_en), 32'h0);
        chk("async_ch_rst_n", 32'(crst_n), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(8);
        apb_rd(5'd4, rd, e);  chk("div1_after_reset", rd, 32'h0);
        apb_rd(5'd0, rd, e);  chk("enr_after_reset", rd, 32'hFF);
        cycles(4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
